// File: rtl/nes_bus_arb.sv
// CPU-side bus arbiter: debugger > OAM sprite DMA > CPU onto one shared slave bus,
// with OR-reduced slave read data and a DMA engine triggered by a CPU write to DMA_ADDR.
module nes_bus_arb #(
   parameter int             AW           = 16,
   parameter int             DW           = 8,
   parameter int             SLAVE_CNT    = 3,
   parameter logic [AW-1:0]  DMA_ADDR     = 16'h4014,
   parameter logic [AW-1:0]  OAMDATA_ADDR = 16'h2004,
   parameter int             DMA_LEN      = 256,
   parameter int             RD_WAIT      = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [AW-1:0]           cpu_a,
   input  logic [DW-1:0]           cpu_dout,
   input  logic                    cpu_r_nw,
   output logic                    cpu_ready,
   output logic [DW-1:0]           cpu_din,
   input  logic                    dbg_active,
   input  logic [AW-1:0]           dbg_a,
   input  logic [DW-1:0]           dbg_dout,
   input  logic                    dbg_r_nw,
   output logic [DW-1:0]           dbg_din,
   output logic [AW-1:0]           bus_a,
   output logic [DW-1:0]           bus_dout,
   output logic                    bus_r_nw,
   input  logic [SLAVE_CNT*DW-1:0] s_dout,
   output logic                    dma_busy
);

   localparam int CW = (DMA_LEN > 1) ? $clog2(DMA_LEN) : 1;
   localparam int WW = (RD_WAIT > 0) ? $clog2(RD_WAIT + 1) : 1;
   localparam logic [CW-1:0] LAST = CW'(DMA_LEN - 1);
   localparam logic [WW-1:0] WMAX = WW'(RD_WAIT);

   typedef enum logic [1:0] {IDLE, ALIGN, READ, WRITE} state_t;

   state_t          r_state, w_next;
   logic [7:0]      r_pg;
   logic [CW-1:0]   r_cnt;
   logic [WW-1:0]   r_wcnt;
   logic [DW-1:0]   r_dbuf;

   logic [DW-1:0]   w_rdata;
   logic            w_trig;
   logic            w_wait;
   logic [AW-1:0]   w_rd_a;
   logic [AW-1:0]   w_dma_a;
   logic            w_dma_r_nw;

   // Slaves drive zero when not addressed, so a plain OR merges them.
   always_comb begin
      w_rdata = '0;
      for (int i = 0; i < SLAVE_CNT; i++) w_rdata = w_rdata | s_dout[i*DW +: DW];
   end

   assign w_trig = (r_state == IDLE) & ~dbg_active & ~cpu_r_nw & (cpu_a == DMA_ADDR);
   assign w_wait = (r_wcnt != WMAX);
   assign w_rd_a = AW'({r_pg, 8'(r_cnt)});

   always_comb begin
      w_next     = r_state;
      w_dma_a    = DMA_ADDR;
      w_dma_r_nw = 1'b1;
      case (r_state)
         IDLE:  if (w_trig) w_next = ALIGN;
         ALIGN: w_next = READ;
         READ: begin
            w_dma_a = w_rd_a;
            if (!w_wait) w_next = WRITE;
         end
         WRITE: begin
            w_dma_a    = OAMDATA_ADDR;
            w_dma_r_nw = 1'b0;
            w_next     = (r_cnt == LAST) ? IDLE : READ;
         end
         default: w_next = IDLE;
      endcase
      // Debugger ownership freezes the engine so the same access is replayed later.
      if (dbg_active) w_next = r_state;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_pg    <= '0;
         r_cnt   <= '0;
         r_wcnt  <= '0;
         r_dbuf  <= '0;
      end else begin
         r_state <= w_next;
         if (!dbg_active) begin
            case (r_state)
               IDLE: if (w_trig) begin
                  r_pg  <= 8'(cpu_dout);
                  r_cnt <= '0;
               end
               ALIGN: r_wcnt <= '0;
               READ: begin
                  if (w_wait) r_wcnt <= r_wcnt + 1'b1;
                  else        r_dbuf <= w_rdata;
               end
               WRITE: if (r_cnt != LAST) begin
                  r_cnt  <= r_cnt + 1'b1;
                  r_wcnt <= '0;
               end
               default: ;
            endcase
         end
      end
   end

   assign dma_busy  = (r_state != IDLE);
   assign cpu_ready = ~dbg_active & ~dma_busy;
   assign cpu_din   = w_rdata;
   assign dbg_din   = w_rdata;

   always_comb begin
      bus_a    = cpu_a;
      bus_dout = cpu_dout;
      bus_r_nw = cpu_r_nw;
      if (dbg_active) begin
         bus_a    = dbg_a;
         bus_dout = dbg_dout;
         bus_r_nw = dbg_r_nw;
      end else if (dma_busy) begin
         bus_a    = w_dma_a;
         bus_dout = r_dbuf;
         bus_r_nw = w_dma_r_nw;
      end
   end

endmodule

// File: tb/tb_nes_bus_arb.sv
// Bench for nes_bus_arb: combinational-RAM instance (RD_WAIT=0) and registered-RAM
// instance (RD_WAIT=1); OAM writes and DMA reads are scoreboarded against queues.
module tb_nes_bus_arb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [15:0] cpu_a, dbg_a, bus_a;
   logic [7:0]  cpu_dout, dbg_dout, cpu_din, dbg_din, bus_dout, s1_val;
   logic        cpu_r_nw, dbg_r_nw, dbg_active, cpu_ready, bus_r_nw, dma_busy;
   logic [23:0] s_dout;

   logic [15:0] u1_cpu_a, u1_bus_a;
   logic [7:0]  u1_cpu_dout, u1_cpu_din, u1_dbg_din, u1_bus_dout, u1_q;
   logic        u1_cpu_r_nw, u1_ready, u1_bus_r_nw, u1_busy;
   logic [23:0] u1_s_dout;

   logic [7:0]  mem [0:2047];

   int n_chk = 0, n_pass = 0;
   int stall0 = 0, stall1 = 0, nwr0 = 0;
   logic [7:0]  exp_d0[$], exp_d1[$];
   logic [15:0] exp_r0[$];

   nes_bus_arb dut0 (
      .clk(clk), .rst(rst), .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_r_nw(cpu_r_nw),
      .cpu_ready(cpu_ready), .cpu_din(cpu_din), .dbg_active(dbg_active), .dbg_a(dbg_a),
      .dbg_dout(dbg_dout), .dbg_r_nw(dbg_r_nw), .dbg_din(dbg_din), .bus_a(bus_a),
      .bus_dout(bus_dout), .bus_r_nw(bus_r_nw), .s_dout(s_dout), .dma_busy(dma_busy)
   );

   nes_bus_arb #(.RD_WAIT(1)) dut1 (
      .clk(clk), .rst(rst), .cpu_a(u1_cpu_a), .cpu_dout(u1_cpu_dout), .cpu_r_nw(u1_cpu_r_nw),
      .cpu_ready(u1_ready), .cpu_din(u1_cpu_din), .dbg_active(1'b0), .dbg_a(16'h0000),
      .dbg_dout(8'h00), .dbg_r_nw(1'b1), .dbg_din(u1_dbg_din), .bus_a(u1_bus_a),
      .bus_dout(u1_bus_dout), .bus_r_nw(u1_bus_r_nw), .s_dout(u1_s_dout), .dma_busy(u1_busy)
   );

   // Slave 0: 2 KB RAM at 0x0000, slave 1: register at 0x0010, slave 2: always 0.
   always_comb s_dout = {8'h00,
                         (bus_a == 16'h0010 && bus_r_nw) ? s1_val : 8'h00,
                         (bus_a[15:11] == 5'd0 && bus_r_nw) ? mem[bus_a[10:0]] : 8'h00};

   always @(posedge clk)
      u1_q <= (u1_bus_a[15:11] == 5'd0 && u1_bus_r_nw) ? mem[u1_bus_a[10:0]] : 8'h00;
   always_comb u1_s_dout = {16'h0000, u1_q};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   always @(negedge clk) if (!rst) begin
      if (!cpu_ready) stall0++;
      if (dbg_active)
         chk("dbg_owns_bus", {8'h00, bus_a, 7'h00, bus_r_nw}, {8'h00, dbg_a, 7'h00, dbg_r_nw});
      else if (dma_busy && bus_r_nw && bus_a != 16'h4014) begin
         if (exp_r0.size() == 0) chk("dma_rd_unexpected", {16'h0, bus_a}, 32'hDEADBEEF);
         else                    chk("dma_rd_addr", {16'h0, bus_a}, {16'h0, exp_r0.pop_front()});
      end
      if (!bus_r_nw && bus_a == 16'h2004) begin
         nwr0++;
         if (exp_d0.size() == 0) chk("oam_wr_unexpected", {24'h0, bus_dout}, 32'hDEADBEEF);
         else                    chk("oam_wr_data", {24'h0, bus_dout}, {24'h0, exp_d0.pop_front()});
      end
   end

   always @(negedge clk) if (!rst) begin
      if (!u1_ready) stall1++;
      if (!u1_bus_r_nw && u1_bus_a == 16'h2004) begin
         if (exp_d1.size() == 0) chk("u1_wr_unexpected", {24'h0, u1_bus_dout}, 32'hDEADBEEF);
         else                    chk("u1_wr_data", {24'h0, u1_bus_dout}, {24'h0, exp_d1.pop_front()});
      end
   end

   task automatic start_dma0();
      @(posedge clk); #1;
      for (int i = 0; i < 256; i++) begin
         exp_d0.push_back(8'(i) ^ 8'h5A);
         exp_r0.push_back(16'h0200 + 16'(i));
      end
      stall0   = 0;
      cpu_a    = 16'h4014;
      cpu_r_nw = 1'b0;
      cpu_dout = 8'h02;
      @(negedge clk);
      chk("trig_wr_seen", {15'h0, bus_r_nw, bus_a}, {16'h0, 16'h4014});
      chk("trig_ready", {31'h0, cpu_ready}, 32'd1);
      @(posedge clk); #1;
      cpu_a    = 16'h0000;
      cpu_r_nw = 1'b1;
   endtask

   task automatic wait_done(input int which);
      int k;
      logic b;
      k = 0;
      do begin
         @(negedge clk);
         k++;
         b = (which == 0) ? dma_busy : u1_busy;
      end while (b && k < 3000);
      chk(which == 0 ? "dma0_done" : "dma1_done", {31'h0, b}, 32'd0);
   endtask

   task automatic wait_wr0(input logic [7:0] idx);
      logic found;
      found = 1'b0;
      for (int k = 0; k < 1000 && !found; k++) begin
         @(negedge clk);
         found = (!bus_r_nw && bus_a == 16'h2004 && bus_dout == (idx ^ 8'h5A));
      end
      chk("wait_wr_byte", {31'h0, found}, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int w;
      rst = 1'b1; dbg_active = 1'b0; dbg_a = 16'h0123; dbg_dout = 8'h00; dbg_r_nw = 1'b1;
      cpu_a = 16'h0000; cpu_dout = 8'h00; cpu_r_nw = 1'b1; s1_val = 8'h00;
      u1_cpu_a = 16'h0000; u1_cpu_dout = 8'h00; u1_cpu_r_nw = 1'b1;
      for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
      for (int i = 0; i < 256; i++) mem[512 + i] = 8'(i) ^ 8'h5A;
      repeat (3) @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", {31'h0, dma_busy}, 32'd0);
      chk("rst_ready", {31'h0, cpu_ready}, 32'd1);
      chk("rst_u1_busy", {31'h0, u1_busy}, 32'd0);
      chk("rst_bus_follows_cpu", {15'h0, bus_r_nw, bus_a}, {16'h1, 16'h0000});

      // Idle pass-through reads and a plain write.
      @(posedge clk); #1 cpu_a = 16'h0010; s1_val = 8'hA5;
      @(negedge clk);
      chk("idle_bus_a", {16'h0, bus_a}, 32'h0010);
      chk("idle_cpu_din", {24'h0, cpu_din}, 32'hA5);
      chk("idle_dbg_din", {24'h0, dbg_din}, 32'hA5);
      chk("idle_ready", {31'h0, cpu_ready}, 32'd1);
      @(posedge clk); #1 cpu_a = 16'h0210;
      @(negedge clk);
      chk("idle_ram_rd", {24'h0, cpu_din}, 32'h4A);
      @(posedge clk); #1 cpu_a = 16'h4014;
      @(negedge clk);
      chk("rd_4014_bus", {15'h0, bus_r_nw, bus_a}, {16'h1, 16'h4014});
      @(posedge clk); #1 cpu_a = 16'h2000; cpu_r_nw = 1'b0; cpu_dout = 8'h80;
      @(negedge clk);
      chk("cpu_wr_pass", {7'h0, bus_r_nw, bus_dout, bus_a}, {8'h00, 8'h80, 16'h2000});
      chk("rd_4014_no_dma", {31'h0, dma_busy}, 32'd0);
      @(posedge clk); #1 cpu_a = 16'h0000; cpu_r_nw = 1'b1;

      // Full DMA, RD_WAIT=0.
      start_dma0();
      wait_done(0);
      chk("dma0_stall", stall0, 32'd513);
      chk("dma0_wr_left", exp_d0.size(), 32'd0);
      chk("dma0_rd_left", exp_r0.size(), 32'd0);
      chk("dma0_ready_after", {31'h0, cpu_ready}, 32'd1);

      // Debugger pre-empts the READ of byte 0x40.
      start_dma0();
      wait_wr0(8'h3F);
      @(posedge clk); #1 dbg_active = 1'b1;
      @(negedge clk);
      chk("preempt_busy_holds", {31'h0, dma_busy}, 32'd1);
      repeat (10) @(posedge clk);
      #1 dbg_active = 1'b0;
      wait_done(0);
      chk("preempt_stall", stall0, 32'd523);
      chk("preempt_wr_left", exp_d0.size(), 32'd0);

      // Reset aborts a DMA at byte 0x80.
      start_dma0();
      wait_wr0(8'h7F);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      exp_d0.delete();
      exp_r0.delete();
      chk("abort_busy", {31'h0, dma_busy}, 32'd0);
      chk("abort_ready", {31'h0, cpu_ready}, 32'd1);
      w = nwr0;
      repeat (40) @(negedge clk);
      chk("abort_no_writes", nwr0, w);

      // Debugger write to the trigger address reaches slaves but never starts DMA.
      @(posedge clk); #1;
      dbg_active = 1'b1; dbg_a = 16'h4014; dbg_r_nw = 1'b0; dbg_dout = 8'h07;
      cpu_a = 16'h4014; cpu_r_nw = 1'b0; cpu_dout = 8'h02;
      @(negedge clk);
      chk("dbgwr_bus", {7'h0, bus_r_nw, bus_dout, bus_a}, {8'h00, 8'h07, 16'h4014});
      chk("dbgwr_ready", {31'h0, cpu_ready}, 32'd0);
      @(posedge clk); #1;
      dbg_active = 1'b0; dbg_a = 16'h0123; dbg_r_nw = 1'b1;
      cpu_a = 16'h0000; cpu_r_nw = 1'b1;
      @(negedge clk);
      chk("dbgwr_no_dma", {30'h0, dma_busy, cpu_ready}, 32'd1);

      // Registered slave, RD_WAIT=1.
      @(posedge clk); #1;
      for (int i = 0; i < 256; i++) exp_d1.push_back(8'(i) ^ 8'h5A);
      stall1 = 0;
      u1_cpu_a = 16'h4014; u1_cpu_r_nw = 1'b0; u1_cpu_dout = 8'h02;
      @(posedge clk); #1 u1_cpu_a = 16'h0000; u1_cpu_r_nw = 1'b1;
      wait_done(1);
      chk("dma1_stall", stall1, 32'd769);
      chk("dma1_wr_left", exp_d1.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/nes_bus_arb.md
Name: nes_bus_arb

Overview:
- Parametrised CPU-side bus arbiter that replaces fixed top-level muxing between the CPU and the debugger.
- Adds a third, internal master: an OAM sprite-DMA engine triggered by a CPU write to DMA_ADDR. It copies DMA_LEN bytes from page {pg,00} to OAMDATA_ADDR while stalling the CPU via ready.
- Drives one shared address/data/r_nw bus to all slaves and OR-reduces SLAVE_CNT slave read buses. Slaves return 0 on a miss.
- Sits between cpu/dbg and cpumc/ppu/jp/apu.

Parameters:
- AW, 16, address width
- DW, 8, data width
- SLAVE_CNT, 3, number of slave read-data buses
- DMA_ADDR, 16'h4014, DMA trigger register address
- OAMDATA_ADDR, 16'h2004, DMA write destination
- DMA_LEN, 256, bytes per DMA (power of 2, ≤256)
- RD_WAIT, 0, extra wait cycles per DMA read (for registered slaves)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cpu_a  in  AW  CPU address
- cpu_dout  in  DW  CPU write data
- cpu_r_nw  in  1  CPU R/!W
- cpu_ready  out  1  CPU ready (0 = stall)
- cpu_din  out  DW  read data to CPU
- dbg_active  in  1  debugger owns bus (break state)
- dbg_a  in  AW  debugger address
- dbg_dout  in  DW  debugger write data
- dbg_r_nw  in  1  debugger R/!W
- dbg_din  out  DW  read data to debugger
- bus_a  out  AW  shared slave address
- bus_dout  out  DW  shared slave write data
- bus_r_nw  out  1  shared slave R/!W
- s_dout  in  SLAVE_CNT*DW  concatenated slave read data
- dma_busy  out  1  DMA in progress

Behaviour:
- Clock, reset and polarity: one clock, clk. Reset rst is synchronous and active-high.
- Read data: rdata = OR of all SLAVE_CNT slices of s_dout (combinational). cpu_din = dbg_din = rdata.
- Bus owner priority (combinational): dbg_active=1 → debugger; else dma_busy=1 → DMA; else CPU. When the DMA does not own the bus, the owner's a/dout/r_nw pass straight to bus_*.
- cpu_ready = ~dbg_active & ~dma_busy.
- dma_busy = (state != IDLE).
- FSM states: IDLE, ALIGN, READ, WRITE. Registers: pg[7:0], cnt[log2(DMA_LEN)-1:0], wcnt (RD_WAIT counter), dbuf[DW-1:0].
- IDLE:
  - Trigger: CPU owns the bus, cpu_r_nw=0 and cpu_a==DMA_ADDR. On trigger: pg<=cpu_dout, cnt<=0, state→ALIGN.
  - The trigger write itself is also presented to the slaves.
  - Debugger writes to DMA_ADDR never trigger.
- ALIGN: one dummy cycle. bus_a=DMA_ADDR, bus_r_nw=1. state→READ, wcnt<=0.
- READ:
  - bus_a={pg,cnt} (low bits cnt, zero-extended), bus_r_nw=1.
  - If wcnt<RD_WAIT: wcnt++, stay.
  - Else: dbuf<=rdata, state→WRITE.
- WRITE:
  - bus_a=OAMDATA_ADDR, bus_r_nw=0, bus_dout=dbuf.
  - If cnt==DMA_LEN-1: state→IDLE. Else cnt++, wcnt<=0, state→READ.
- Latency: with RD_WAIT=0, cpu_ready is low for exactly 1+2*DMA_LEN cycles starting the cycle after the trigger (513 for 256 bytes). In general, 1+DMA_LEN*(2+RD_WAIT).
- dbg_active=1 mid-DMA: the FSM freezes. State, cnt, wcnt and dbuf hold, and the debugger drives the bus. When dbg_active drops, the DMA resumes in the same state and issues the same access again.
- Address wrap: cnt wraps within the page. pg never increments.
- Reset: state=IDLE, pg=0, cnt=0, wcnt=0, dbuf=0. Outputs after reset: dma_busy=0, cpu_ready=~dbg_active, bus_* follow the CPU (or the debugger if dbg_active). A reset mid-DMA aborts it; cpu_ready returns to 1 the next cycle.
- CPU reads of DMA_ADDR: ordinary bus reads, no side effect.

Test Plan:
- Idle pass-through: dbg_active=0, CPU reads 16'h0010 with s_dout slice1=8'hA5, others 0 → bus_a=16'h0010, cpu_din=8'hA5, cpu_ready=1.
- DMA, RD_WAIT=0: preload RAM page 2 with i^8'h5A at offset i. CPU writes 8'h02 to 16'h4014 → cpu_ready=0 for 513 cycles. Slave log shows 256 writes to 16'h2004 with data i^8'h5A in order, and reads at 16'h0200..16'h02FF. Afterwards dma_busy=0, cpu_ready=1.
- Debug pre-emption: assert dbg_active for 10 cycles during the READ of byte 0x40 → bus driven by dbg_* during those cycles. Byte 0x40 is re-read and written once, the total written sequence is unchanged, and the stall lasts 523 cycles.
- Reset mid-DMA: pulse rst at byte 0x80 → the next cycle shows dma_busy=0 and cpu_ready=1, and no further writes to 16'h2004 occur.
- Registered slave, RD_WAIT=1 with a 1-cycle-latency RAM model → correct data copied, stall = 1+256*3 = 769 cycles.
- Debugger write to 16'h4014 with dbg_active=1 → the slave sees the write, dma_busy stays 0.
